// File: rtl/wb_regfile.sv
`default_nettype none
// ============================================================================
// Module      : wb_regfile
// Description : MIPS write-back stage and 32-entry architectural register
//               file. Selects the write-back value (load data or ALU result),
//               commits it to the GPRs, counts committed writes, and serves
//               two combinational read ports for the ID stage.
// Ports       : clk, reset            - clock, synchronous active-high reset
//               MemToReg_wb           - 1 = MemDout_wb, 0 = ALUResult_wb
//               RegWrite_wb           - write-back enable
//               RegWriteAddr_wb       - destination register number
//               ALUResult_wb          - ALU result from MEM/WB
//               MemDout_wb            - load data from MEM/WB
//               RsAddr_id, RtAddr_id  - read port addresses (ID stage)
//               RsData_id, RtData_id  - read port data (combinational)
//               WriteData_wb          - selected write-back value (to EX fwd)
//               WbCount               - committed writes since reset
// Options     : WB_REGFILE_BYPASS_EN - when defined, a read of the register
//               being written in the same cycle returns the new value.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  MemToReg_wb,
    input  logic                  RegWrite_wb,
    input  logic [4:0]            RegWriteAddr_wb,
    input  logic [DATA_WIDTH-1:0] ALUResult_wb,
    input  logic [DATA_WIDTH-1:0] MemDout_wb,
    input  logic [4:0]            RsAddr_id,
    input  logic [4:0]            RtAddr_id,
    output logic [DATA_WIDTH-1:0] RsData_id,
    output logic [DATA_WIDTH-1:0] RtData_id,
    output logic [DATA_WIDTH-1:0] WriteData_wb,
    output logic [CNT_WIDTH-1:0]  WbCount
);

    localparam logic [CNT_WIDTH-1:0]  c_cnt_one  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DATA_WIDTH-1:0] c_zero     = '0;

    // $0 is hard-wired to zero, so only 1..31 have storage.
    logic [DATA_WIDTH-1:0] r_regs [1:31];
    logic [CNT_WIDTH-1:0]  r_count;

    logic                  w_we;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [DATA_WIDTH-1:0] w_rs_stored;
    logic [DATA_WIDTH-1:0] w_rt_stored;

    assign w_wdata      = MemToReg_wb ? MemDout_wb : ALUResult_wb;
    assign WriteData_wb = w_wdata;

    // Writes to $0 and writes coinciding with reset are dropped; gating with
    // reset here also disables the bypass path while reset is asserted.
    assign w_we = RegWrite_wb & (RegWriteAddr_wb != 5'd0) & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 1; i < 32; i++) begin
                r_regs[i] <= c_zero;
            end
            r_count <= '0;
        end else if (w_we) begin
            r_regs[RegWriteAddr_wb] <= w_wdata;
            r_count                 <= r_count + c_cnt_one;
        end
    end

    assign WbCount = r_count;

    always_comb begin
        w_rs_stored = c_zero;
        w_rt_stored = c_zero;
        if (RsAddr_id != 5'd0) begin
            w_rs_stored = r_regs[RsAddr_id];
        end
        if (RtAddr_id != 5'd0) begin
            w_rt_stored = r_regs[RtAddr_id];
        end
    end

`ifdef WB_REGFILE_BYPASS_EN
    // Write-then-read: a port addressing the register being committed this
    // cycle sees the incoming value. w_we already excludes $0 and reset.
    assign RsData_id = (w_we && (RegWriteAddr_wb == RsAddr_id)) ? w_wdata : w_rs_stored;
    assign RtData_id = (w_we && (RegWriteAddr_wb == RtAddr_id)) ? w_wdata : w_rt_stored;
`else
    // Stored contents only; the hazard unit covers the WB-to-ID case.
    assign RsData_id = w_rs_stored;
    assign RtData_id = w_rt_stored;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_regfile.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_regfile
// Description : Self-checking bench for wb_regfile. Directed scenarios plus
//               randomized traffic compared against an array-based model of
//               the architectural register file. A second instance with a
//               4-bit counter exercises counter wrap-around.
// Options     : WB_REGFILE_BYPASS_EN - must match the RTL build.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_regfile;

    logic        clk;
    logic        reset;
    logic        MemToReg_wb;
    logic        RegWrite_wb;
    logic [4:0]  RegWriteAddr_wb;
    logic [31:0] ALUResult_wb;
    logic [31:0] MemDout_wb;
    logic [4:0]  RsAddr_id;
    logic [4:0]  RtAddr_id;
    logic [31:0] RsData_id;
    logic [31:0] RtData_id;
    logic [31:0] WriteData_wb;
    logic [31:0] WbCount;

    logic [31:0] s_rs;
    logic [31:0] s_rt;
    logic [31:0] s_wd;
    logic [3:0]  s_cnt;

    wb_regfile #(.DATA_WIDTH(32), .CNT_WIDTH(32)) u_dut (
        .clk            (clk),
        .reset          (reset),
        .MemToReg_wb    (MemToReg_wb),
        .RegWrite_wb    (RegWrite_wb),
        .RegWriteAddr_wb(RegWriteAddr_wb),
        .ALUResult_wb   (ALUResult_wb),
        .MemDout_wb     (MemDout_wb),
        .RsAddr_id      (RsAddr_id),
        .RtAddr_id      (RtAddr_id),
        .RsData_id      (RsData_id),
        .RtData_id      (RtData_id),
        .WriteData_wb   (WriteData_wb),
        .WbCount        (WbCount)
    );

    wb_regfile #(.DATA_WIDTH(32), .CNT_WIDTH(4)) u_dut_small (
        .clk            (clk),
        .reset          (reset),
        .MemToReg_wb    (MemToReg_wb),
        .RegWrite_wb    (RegWrite_wb),
        .RegWriteAddr_wb(RegWriteAddr_wb),
        .ALUResult_wb   (ALUResult_wb),
        .MemDout_wb     (MemDout_wb),
        .RsAddr_id      (RsAddr_id),
        .RtAddr_id      (RtAddr_id),
        .RsData_id      (s_rs),
        .RtData_id      (s_rt),
        .WriteData_wb   (s_wd),
        .WbCount        (s_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: architectural state as a plain array plus a count.
    logic [31:0] m_regs [0:31];
    longint      m_count;

    int n_cmp;
    int n_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] a, input logic rst,
                                               input logic rw, input logic [4:0] wa,
                                               input logic [31:0] wd);
        if (a == 5'd0) return 32'd0;
`ifdef WB_REGFILE_BYPASS_EN
        if (!rst && rw && wa == a) return wd;
`endif
        return m_regs[a];
    endfunction

    // One pipeline cycle: drive, check combinational outputs mid-cycle,
    // then apply the edge to the model.
    task automatic step(input logic rst, input logic rw, input logic m2r,
                        input logic [4:0] wa, input logic [31:0] alu,
                        input logic [31:0] mem, input logic [4:0] ra,
                        input logic [4:0] rb);
        logic [31:0] wd;
        reset = rst; RegWrite_wb = rw; MemToReg_wb = m2r; RegWriteAddr_wb = wa;
        ALUResult_wb = alu; MemDout_wb = mem; RsAddr_id = ra; RtAddr_id = rb;
        wd = m2r ? mem : alu;
        @(negedge clk);
        chk("wdata", {32'd0, WriteData_wb}, {32'd0, wd});
        chk("rs",    {32'd0, RsData_id},    {32'd0, model_read(ra, rst, rw, wa, wd)});
        chk("rt",    {32'd0, RtData_id},    {32'd0, model_read(rb, rst, rw, wa, wd)});
        chk("cnt",   {32'd0, WbCount},      {32'd0, m_count[31:0]});
        chk("cnt4",  {60'd0, s_cnt},        {60'd0, m_count[3:0]});
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
            m_count = 0;
        end else if (rw && wa != 5'd0) begin
            m_regs[wa] = wd;
            m_count    = m_count + 1;
        end
        #1;
    endtask

    // Directed read check against literal expectations, no write pending.
    task automatic peek(input string tag, input logic [4:0] ra, input logic [4:0] rb,
                        input logic [31:0] exp_rs, input logic [31:0] exp_rt,
                        input logic [31:0] exp_cnt);
        reset = 1'b0; RegWrite_wb = 1'b0; RsAddr_id = ra; RtAddr_id = rb;
        #1;
        chk({tag, "_rs"},  {32'd0, RsData_id}, {32'd0, exp_rs});
        chk({tag, "_rt"},  {32'd0, RtData_id}, {32'd0, exp_rt});
        chk({tag, "_cnt"}, {32'd0, WbCount},   {32'd0, exp_cnt});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp = 0; n_err = 0; m_count = 0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        reset = 1'b1; RegWrite_wb = 1'b0; MemToReg_wb = 1'b0; RegWriteAddr_wb = 5'd0;
        ALUResult_wb = 32'd0; MemDout_wb = 32'd0; RsAddr_id = 5'd0; RtAddr_id = 5'd0;
        @(posedge clk); #1;

        // Reset then read
        step(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd5, 5'd31);
        peek("rst_read", 5'd5, 5'd31, 32'd0, 32'd0, 32'd0);

        // ALU write then load write
        step(1'b0, 1'b1, 1'b0, 5'd3, 32'h0000_1234, 32'h5555_0000, 5'd0, 5'd0);
        peek("alu_wr", 5'd3, 5'd3, 32'h0000_1234, 32'h0000_1234, 32'd1);
        step(1'b0, 1'b1, 1'b1, 5'd3, 32'h0BAD_0000, 32'hDEAD_BEEF, 5'd3, 5'd0);
        peek("ld_wr", 5'd3, 5'd0, 32'hDEAD_BEEF, 32'd0, 32'd2);

        // $0 protection and disabled write
        step(1'b0, 1'b1, 1'b0, 5'd0, 32'hFFFF_FFFF, 32'd0, 5'd0, 5'd0);
        peek("r0", 5'd0, 5'd0, 32'd0, 32'd0, 32'd2);
        step(1'b0, 1'b0, 1'b0, 5'd7, 32'hCAFE_F00D, 32'd0, 5'd7, 5'd7);
        peek("nowr", 5'd7, 5'd3, 32'd0, 32'hDEAD_BEEF, 32'd2);

        // Same-cycle read of write target
        step(1'b0, 1'b1, 1'b0, 5'd9, 32'h0000_0011, 32'd0, 5'd0, 5'd0);
        RegWrite_wb = 1'b1; MemToReg_wb = 1'b0; RegWriteAddr_wb = 5'd9;
        ALUResult_wb = 32'hA5A5_A5A5; RsAddr_id = 5'd9; RtAddr_id = 5'd9; reset = 1'b0;
        #1;
`ifdef WB_REGFILE_BYPASS_EN
        chk("byp_rs", {32'd0, RsData_id}, {32'd0, 32'hA5A5_A5A5});
        chk("byp_rt", {32'd0, RtData_id}, {32'd0, 32'hA5A5_A5A5});
`else
        chk("old_rs", {32'd0, RsData_id}, {32'd0, 32'h0000_0011});
        chk("old_rt", {32'd0, RtData_id}, {32'd0, 32'h0000_0011});
`endif
        step(1'b0, 1'b1, 1'b0, 5'd9, 32'hA5A5_A5A5, 32'd0, 5'd9, 5'd9);
        peek("after_wr9", 5'd9, 5'd9, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'd4);

        // Reset mid-operation
        for (int i = 1; i <= 4; i++)
            step(1'b0, 1'b1, 1'b0, 5'(i), 32'h100 + 32'(i), 32'd0, 5'd0, 5'd0);
        peek("filled", 5'd2, 5'd4, 32'h102, 32'h104, 32'd8);
        step(1'b1, 1'b1, 1'b0, 5'd2, 32'h0000_0077, 32'd0, 5'd2, 5'd4);
        for (int i = 1; i <= 4; i++)
            peek("mid_rst", 5'(i), 5'd9, 32'd0, 32'd0, 32'd0);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            logic [4:0] wa, ra, rb;
            wa = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            ra = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom);
            rb = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom);
            step(($urandom_range(0, 59) == 0), 1'($urandom), 1'($urandom), wa,
                 $urandom, $urandom, ra, rb);
        end

        // Counter wrap on the 4-bit instance: 17 valid writes from reset
        step(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0);
        for (int n = 0; n < 17; n++)
            step(1'b0, 1'b1, 1'b0, 5'($urandom_range(1, 31)), $urandom, 32'd0, 5'd1, 5'd2);
        chk("wrap4", {60'd0, s_cnt}, 64'd1);
        chk("cnt17", {32'd0, WbCount}, 64'd17);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_regfile.md
# wb_regfile

Write-back stage and architectural register file of the five-stage MIPS pipeline. Consumes the registered write-back controls and data leaving the MEM/WB pipeline register. Selects the write-back value, commits it to a 32-entry general-purpose register file, and serves the two combinational read ports used by the ID stage. Write-back to ID same-cycle bypass is optional and controlled at compile time.

## Interface
Parameters:
- DATA_WIDTH, 32, register and data width
- CNT_WIDTH, 32, width of the committed-write counter

Ports:
- clk  input  1  pipeline clock; all state updates on posedge
- reset  input  1  synchronous, active-high reset
- MemToReg_wb  input  1  1 = write MemDout_wb, 0 = write ALUResult_wb
- RegWrite_wb  input  1  write-back enable
- RegWriteAddr_wb  input  5  destination register number
- ALUResult_wb  input  DATA_WIDTH  ALU result from MEM/WB
- MemDout_wb  input  DATA_WIDTH  load data from MEM/WB
- RsAddr_id  input  5  read port A address (ID stage)
- RtAddr_id  input  5  read port B address (ID stage)
- RsData_id  output  DATA_WIDTH  read port A data, combinational
- RtData_id  output  DATA_WIDTH  read port B data, combinational
- WriteData_wb  output  DATA_WIDTH  selected write-back value, combinational; feeds EX forwarding
- WbCount  output  CNT_WIDTH  number of committed register writes since reset

## Operation
- WriteData_wb = MemToReg_wb ? MemDout_wb : ALUResult_wb. This output is independent of RegWrite_wb.
- Effective write: we = RegWrite_wb & (RegWriteAddr_wb != 0) & ~reset.
- On posedge with we: regs[RegWriteAddr_wb] <= WriteData_wb, and WbCount <= WbCount + 1 (modulo 2^CNT_WIDTH; all ones wraps to 0).
- Register $0 has no storage. Reads of address 0 always return 0. Writes to $0 are dropped and do not increment WbCount.
- Read data = regs[addr] (0 for addr 0), subject to the bypass rule in Configuration.
- Both read ports are independent. Identical addresses on both ports are legal and return identical data.
- No other state exists. There are no stalls and no handshake. A write is committed on every edge where we = 1.

## Timing
- Reset: on a posedge with reset = 1, all 31 storage registers go to 0 and WbCount goes to 0. Any write presented in that cycle is discarded.
- Reset asserted mid-stream: the write present on the reset edge is lost. Writes committed on earlier edges are cleared by the same edge.
- After reset, every read returns 0 until a write commits.
- Write latency: a value presented in cycle N is in storage after the posedge ending cycle N. Reads in cycle N+1 return it regardless of configuration.
- Read latency: zero cycles (combinational from address and storage).
- WbCount reflects writes committed up to and including the last posedge.
- While reset = 1, the bypass path is disabled, so reads return stored values.

## Configuration
- Macro: WB_REGFILE_BYPASS_EN.
- Defined:
  - If we = 1 and RegWriteAddr_wb equals a nonzero read address, that port returns WriteData_wb in the same cycle (write-then-read semantics).
  - This resolves the WB-to-ID hazard without a stall.
- Undefined:
  - Read ports return stored contents only. A same-cycle read of the register being written returns the old value.
  - The hazard unit must insert the extra stall.
- All other behaviour is identical in both builds.

## Test plan
- Reset then read: assert reset one cycle, deassert, read Rs=5 and Rt=31 -> RsData_id = RtData_id = 0, WbCount = 0.
- ALU write, then load write:
  - RegWrite=1, MemToReg=0, addr=3, ALUResult=0x0000_1234 -> next cycle Rs=3 reads 0x0000_1234, WbCount = 1.
  - MemToReg=1, MemDout=0xDEAD_BEEF, addr=3 -> reads 0xDEAD_BEEF, WbCount = 2.
- $0 protection: RegWrite=1, addr=0, ALUResult=0xFFFF_FFFF -> Rs=0 reads 0, WbCount unchanged. RegWrite=0, addr=7 -> reg 7 unchanged, count unchanged.
- Same-cycle read of write target: write 0xA5A5_A5A5 to reg 9 while Rs=Rt=9, reg 9 previously 0x11:
  - With WB_REGFILE_BYPASS_EN: both ports read 0xA5A5_A5A5 in that cycle.
  - Without it: both read 0x11 in that cycle, then 0xA5A5_A5A5 next cycle.
- Reset mid-operation: fill regs 1..4, then present a write to reg 2 (value 0x77) in the same cycle reset = 1:
  - Bypass is suppressed, and all regs read 0 afterward.
  - Reg 2 is 0, not 0x77, and WbCount = 0.
- Counter wrap: build with CNT_WIDTH=4 and perform 17 valid writes -> WbCount = 1.
